// File: rtl/music_rom_player.sv
// ---------------------------------------------------------------------------
// music_rom_player
//   Walks a song stored in a block ROM and turns each note word into a
//   square wave on the buzzer pin.
//   Each ROM word holds a half-period and a duration:
//     [31:16] half-period in clk cycles (0 = rest)
//     [15:0]  duration in ticks of TICK_DIV clocks
//   32'hFFFF_FFFF marks the end of the song.
//   A short silent gap of GAP_TICKS ticks follows every sounding note.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   start       one-cycle request to play from address 0 (only honoured when idle)
//   stop        one-cycle request to abort playback (wins over start)
//   rom_addr_o  ROM read address
//   rom_en_o    ROM read enable; data returns on rom_data_i one cycle later
//   rom_data_i  ROM read data
//   tone_o      square-wave audio output
//   note_div_o  half-period of the note being played, 0 while silent
//   playing_o   high from the first fetch until the player is idle again
//   done_o      one-cycle pulse when the song ends on its own
// ---------------------------------------------------------------------------
module music_rom_player #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_TICKS  = 10,
  parameter int LOOP       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_en_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  tone_o,
  output logic [15:0]           note_div_o,
  output logic                  playing_o,
  output logic                  done_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0]           GAP_LOAD   = 16'(GAP_TICKS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [31:0]           END_MARKER = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_GAP,
    S_ADVANCE,
    S_END
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             div_q, div_d;
  logic [15:0]             dur_q, dur_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [15:0]             tone_cnt_q, tone_cnt_d;
  logic                    tone_q, tone_d;
  logic                    done_q, done_d;

  logic [15:0] word_div;
  logic [15:0] word_dur;
  logic        word_is_marker;
  logic        tick_wrap;
  logic        last_tick;

  // Field decode of the word returned by the ROM; only used while in LATCH.
  always_comb begin
    word_div       = rom_data_i[31:16];
    word_dur       = rom_data_i[15:0];
    word_is_marker = (rom_data_i[31:0] == END_MARKER);
  end

  // The prescaler and the tick counter are shared by PLAY and GAP, so the
  // "last clock of the last tick" condition is common to both states.
  always_comb begin
    tick_wrap = (presc_q == PRESC_LAST);
    last_tick = tick_wrap && (dur_q == 16'd1);
  end

  // State register plus all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      div_q      <= '0;
      dur_q      <= '0;
      presc_q    <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      div_q      <= div_d;
      dur_q      <= dur_d;
      presc_q    <= presc_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. Stop overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   state_d = S_LATCH;
      S_LATCH: begin
        if (word_is_marker)        state_d = S_END;
        else if (word_dur == '0)   state_d = S_ADVANCE;
        else                       state_d = S_PLAY;
      end
      S_PLAY: begin
        if (last_tick) state_d = (GAP_TICKS == 0) ? S_ADVANCE : S_GAP;
      end
      S_GAP:     if (last_tick) state_d = S_ADVANCE;
      // The last address never wraps; running off the ROM ends the song.
      S_ADVANCE: state_d = (addr_q == ADDR_LAST) ? S_END : S_FETCH;
      S_END:     state_d = (LOOP != 0) ? S_FETCH : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
  end

  // Datapath: address, note registers, tick timing and tone generation.
  // Leaving PLAY always silences the output and reloads the tick counter
  // with the gap length so GAP can reuse the same countdown.
  always_comb begin
    addr_d     = addr_q;
    div_d      = div_q;
    dur_d      = dur_q;
    presc_d    = presc_q;
    tone_cnt_d = tone_cnt_q;
    tone_d     = tone_q;
    done_d     = 1'b0;
    case (state_q)
      S_LATCH: begin
        if (!word_is_marker && (word_dur != '0)) begin
          div_d      = word_div;
          dur_d      = word_dur;
          presc_d    = '0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
        end
      end
      S_PLAY: begin
        presc_d = tick_wrap ? '0 : presc_q + 1'b1;
        if (tick_wrap) dur_d = dur_q - 16'd1;
        // Tone phase flips every div_q clocks; a rest (div 0) stays low.
        if (div_q == '0) begin
          tone_d     = 1'b0;
          tone_cnt_d = '0;
        end else if (tone_cnt_q == div_q - 16'd1) begin
          tone_d     = ~tone_q;
          tone_cnt_d = '0;
        end else begin
          tone_cnt_d = tone_cnt_q + 16'd1;
        end
        if (last_tick) begin
          tone_d     = 1'b0;
          tone_cnt_d = '0;
          div_d      = '0;
          presc_d    = '0;
          dur_d      = GAP_LOAD;
        end
      end
      S_GAP: begin
        presc_d = tick_wrap ? '0 : presc_q + 1'b1;
        if (tick_wrap) dur_d = dur_q - 16'd1;
      end
      S_ADVANCE: begin
        if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
      end
      S_END: begin
        addr_d = '0;
        done_d = (LOOP == 0);
      end
      default: ;
    endcase
    if (stop) begin
      addr_d     = '0;
      div_d      = '0;
      dur_d      = '0;
      presc_d    = '0;
      tone_cnt_d = '0;
      tone_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    rom_en_o  = (state_q == S_FETCH);
    playing_o = (state_q != S_IDLE);
  end

  assign rom_addr_o = addr_q;
  assign tone_o     = tone_q;
  assign note_div_o = div_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_music_rom_player.sv
// ---------------------------------------------------------------------------
// tb_music_rom_player
//   Three players share one clock: a plain one, a looping one and one with a
//   2-bit address. Each has a small ROM model with one cycle of read latency.
//   When a song is started the expected cycle-by-cycle output trace is
//   expanded from the song words and queued with the cycle it is due in; a
//   monitor on the falling edge pops and compares whatever is due.
// ---------------------------------------------------------------------------
module tb_music_rom_player;

  localparam int TICK = 4;
  localparam int GAP  = 1;
  localparam logic [31:0] MARK = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        en;
    logic [15:0] addr;
    logic        tone;
    logic [15:0] div;
    logic        playing;
    logic        done;
  } obs_t;

  typedef struct {
    int unsigned due;
    obs_t        exp;
    string       tag;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = '0;
  logic [2:0] stop = '0;

  logic [15:0] addr0, addr1;
  logic [1:0]  addr2;
  logic [2:0]  en;
  logic [31:0] data0, data1, data2;
  logic [2:0]  tone, playing, done;
  logic [15:0] div0, div1, div2;

  logic [31:0] rom0 [16];
  logic [31:0] rom1 [16];
  logic [31:0] rom2 [4];

  sb_t         sb [$];
  sb_t         ent;
  int unsigned cyc = 0;
  int unsigned tNext = 0;
  int          pushBudget = 0;
  int          sel = 0;
  string       curTag = "";
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM models: registered read, one cycle latency.
  always @(posedge clk) begin
    if (en[0]) data0 <= rom0[addr0[3:0]];
    if (en[1]) data1 <= rom1[addr1[3:0]];
    if (en[2]) data2 <= rom2[addr2];
  end

  music_rom_player #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TICK_DIV(TICK), .GAP_TICKS(GAP), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .stop(stop[0]),
    .rom_addr_o(addr0), .rom_en_o(en[0]), .rom_data_i(data0),
    .tone_o(tone[0]), .note_div_o(div0), .playing_o(playing[0]), .done_o(done[0])
  );

  music_rom_player #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TICK_DIV(TICK), .GAP_TICKS(GAP), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .stop(stop[1]),
    .rom_addr_o(addr1), .rom_en_o(en[1]), .rom_data_i(data1),
    .tone_o(tone[1]), .note_div_o(div1), .playing_o(playing[1]), .done_o(done[1])
  );

  music_rom_player #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .TICK_DIV(TICK), .GAP_TICKS(GAP), .LOOP(0)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .stop(stop[2]),
    .rom_addr_o(addr2), .rom_en_o(en[2]), .rom_data_i(data2),
    .tone_o(tone[2]), .note_div_o(div2), .playing_o(playing[2]), .done_o(done[2])
  );

  function automatic obs_t observe(input int which);
    obs_t o;
    case (which)
      0:       o = {en[0], addr0, tone[0], div0, playing[0], done[0]};
      1:       o = {en[1], addr1, tone[1], div1, playing[1], done[1]};
      default: o = {en[2], 14'd0, addr2, tone[2], div2, playing[2], done[2]};
    endcase
    return o;
  endfunction

  function automatic logic [31:0] romWord(input int which, input int a);
    case (which)
      0:       return rom0[a % 16];
      1:       return rom1[a % 16];
      default: return rom2[a % 4];
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Compare every queued expectation that has come due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      ent = sb.pop_front();
      checkOutput($sformatf("%s@%0d", ent.tag, ent.due), 64'(observe(sel)), 64'(ent.exp));
    end
  end

  task automatic pushExp(input logic e, input int a, input logic t, input logic [15:0] d,
                         input logic p, input logic dn);
    sb_t s;
    if (pushBudget > 0) begin
      s.due = tNext;
      s.exp = {e, 16'(a), t, d, p, dn};
      s.tag = curTag;
      sb.push_back(s);
      tNext++;
      pushBudget--;
    end
  endtask

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) pushExp(1'b0, 0, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  // Expand a song into its expected per-cycle trace: FETCH, LATCH, then
  // duration*TICK clocks of tone, GAP*TICK silent clocks and one ADVANCE.
  task automatic pushSong(input int which, input int addrLast, input bit loopMode);
    int          a = 0;
    logic [31:0] w;
    logic [15:0] d;
    while (pushBudget > 0) begin
      w = romWord(which, a);
      d = w[31:16];
      pushExp(1'b1, a, 1'b0, 16'd0, 1'b1, 1'b0);
      pushExp(1'b0, a, 1'b0, 16'd0, 1'b1, 1'b0);
      if (w == MARK) begin
        pushExp(1'b0, a, 1'b0, 16'd0, 1'b1, 1'b0);
        if (loopMode) begin
          a = 0;
          continue;
        end
        pushExp(1'b0, 0, 1'b0, 16'd0, 1'b0, 1'b1);
        break;
      end
      if (w[15:0] != 16'd0) begin
        for (int k = 0; k < int'(w[15:0]) * TICK; k++)
          pushExp(1'b0, a, (d == 16'd0) ? 1'b0 : 1'((k / int'(d)) % 2), d, 1'b1, 1'b0);
        for (int k = 0; k < GAP * TICK; k++)
          pushExp(1'b0, a, 1'b0, 16'd0, 1'b1, 1'b0);
      end
      pushExp(1'b0, a, 1'b0, 16'd0, 1'b1, 1'b0);
      if (a == addrLast) begin
        pushExp(1'b0, a, 1'b0, 16'd0, 1'b1, 1'b0);
        pushExp(1'b0, 0, 1'b0, 16'd0, 1'b0, 1'b1);
        break;
      end
      a++;
    end
  endtask

  task automatic waitUntil(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle pulse on start and/or stop of the selected player.
  task automatic applyStimulus(input int which, input bit doStart, input bit doStop);
    start[which] = doStart;
    stop[which]  = doStop;
    @(posedge clk);
    #1;
    start[which] = 1'b0;
    stop[which]  = 1'b0;
  endtask

  task automatic drain();
    waitUntil(tNext + 1);
    checkOutput({curTag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic runFull(input int which, input int addrLast, input string tag);
    sel        = which;
    curTag     = tag;
    tNext      = cyc + 1;
    pushBudget = 100000;
    pushSong(which, addrLast, 1'b0);
    pushIdle(2);
    applyStimulus(which, 1'b1, 1'b0);
    drain();
  endtask

  // Play the first 'budget' cycles of a song, then abort with stop or rst
  // and expect an idle player with no done pulse.
  task automatic runTruncated(input int which, input int budget, input bit useReset, input string tag);
    int unsigned c0;
    sel        = which;
    curTag     = tag;
    c0         = cyc;
    tNext      = c0 + 1;
    pushBudget = budget;
    pushSong(which, 65535, which == 1);
    applyStimulus(which, 1'b1, 1'b0);
    waitUntil(c0 + budget);
    pushBudget = 100;
    curTag     = {tag, "_abort"};
    pushIdle(4);
    if (useReset) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end else begin
      applyStimulus(which, 1'b0, 1'b1);
    end
    drain();
  endtask

  initial begin
    int unsigned c0;
    for (int i = 0; i < 16; i++) begin
      rom0[i] = MARK;
      rom1[i] = MARK;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset0", 64'(observe(0)), 64'd0);
    checkOutput("reset1", 64'(observe(1)), 64'd0);
    checkOutput("reset2", 64'(observe(2)), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] single note then marker");
    rom0[0] = 32'h0003_0002;
    rom0[1] = MARK;
    runFull(0, 65535, "t1");

    $display("[TB] rest, zero-length word, short note, start during play ignored");
    rom0[0] = 32'h0000_0003;
    rom0[1] = 32'h0005_0000;
    rom0[2] = 32'h0002_0001;
    rom0[3] = MARK;
    sel        = 0;
    curTag     = "t2";
    c0         = cyc;
    tNext      = c0 + 1;
    pushBudget = 100000;
    pushSong(0, 65535, 1'b0);
    pushIdle(2);
    applyStimulus(0, 1'b1, 1'b0);
    waitUntil(c0 + 6);
    applyStimulus(0, 1'b1, 1'b0);
    waitUntil(c0 + 24);
    applyStimulus(0, 1'b1, 1'b0);
    drain();

    $display("[TB] stop mid-note, then restart");
    rom0[0] = 32'h0003_0008;
    rom0[1] = MARK;
    runTruncated(0, 7, 1'b0, "t3stop");
    runTruncated(0, 4, 1'b0, "t3restart");

    $display("[TB] reset mid-note");
    runTruncated(0, 9, 1'b1, "t3rst");

    $display("[TB] start and stop together while idle");
    sel        = 0;
    curTag     = "t4idle";
    tNext      = cyc + 1;
    pushBudget = 100;
    pushIdle(4);
    applyStimulus(0, 1'b1, 1'b1);
    drain();

    $display("[TB] looping song");
    rom1[0] = 32'h0002_0001;
    rom1[1] = MARK;
    runTruncated(1, 42, 1'b0, "t5loop");

    $display("[TB] 2-bit address, no marker");
    rom2[0] = 32'h0002_0001;
    rom2[1] = 32'h0000_0001;
    rom2[2] = 32'h0001_0001;
    rom2[3] = 32'h0003_0002;
    runFull(2, 3, "t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
